// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift-register chain (PISO, SIPO and later stages).
package shift_reg_pkg;

   // Serializer FSM encoding: IDLE = 0, SHIFT = 1.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Counter width able to hold 0..n inclusive: clog2(n)+1.
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 while enabled and strobes
// `tick` on the last count of each period.
module bit_tick_gen
   import shift_reg_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int            DW   = cnt_width(CLKS_PER_BIT);
   localparam logic [DW-1:0] LAST = DW'(CLKS_PER_BIT - 1);

   logic [DW-1:0] div_reg;

   // Tick decodes only from registered state (en is a register decode upstream).
   assign tick = en && (div_reg == LAST);

   // Divider counter: cleared while held off, wraps to 0 on each tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_reg <= '0;
      end else if (clr || tick) begin
         div_reg <= '0;
      end else if (en) begin
         div_reg <= div_reg + DW'(1);
      end
   end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: valid/ready word input with a one-entry
// hold buffer, MSB-first serial output with a shift_en strobe per bit.
module piso_serializer
   import shift_reg_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 1
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             serial_out,
   output logic             shift_en,
   output logic             word_done,
   output logic             busy
);

   localparam int            BW       = cnt_width(WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   state_t           state_reg;
   state_t           state_next;
   logic [WIDTH-1:0] shreg_reg;
   logic [WIDTH-1:0] hold_data_reg;
   logic             hold_valid_reg;
   logic [BW-1:0]    bit_cnt_reg;
   logic             accept;
   logic             load;
   logic             in_shift;

   assign in_shift = (state_reg == SHIFT);

   // Accept is gated only by the hold buffer, never by an active word.
   assign accept = in_valid && !hold_valid_reg;

   // Bit pacing; the divider is held at zero whenever nothing is shifting.
   bit_tick_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (!in_shift),
      .en    (in_shift),
      .tick  (shift_en)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state, buffer-to-shifter load decision and registered-output decodes.
   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      word_done  = shift_en && (bit_cnt_reg == LAST_BIT);
      in_ready   = !hold_valid_reg;
      serial_out = in_shift ? shreg_reg[WIDTH-1] : 1'b0;
      busy       = in_shift || hold_valid_reg;
      case (state_reg)
         IDLE: begin
            if (hold_valid_reg) begin
               load       = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (word_done) begin
               // Reload with no gap if a word is already waiting.
               if (hold_valid_reg) begin
                  load = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Hold buffer: filled on accept, drained on load (never both in one cycle).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_data_reg  <= '0;
         hold_valid_reg <= 1'b0;
      end else if (accept) begin
         hold_data_reg  <= in_data;
         hold_valid_reg <= 1'b1;
      end else if (load) begin
         hold_valid_reg <= 1'b0;
      end
   end

   // Shift register and bit counter: load a fresh word or advance one bit per strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_reg   <= '0;
         bit_cnt_reg <= '0;
      end else if (load) begin
         shreg_reg   <= hold_data_reg;
         bit_cnt_reg <= '0;
      end else if (shift_en) begin
         shreg_reg   <= {shreg_reg[WIDTH-2:0], 1'b0};
         bit_cnt_reg <= bit_cnt_reg + BW'(1);
      end
   end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out transmitter that directly feeds the SIPO stage of the shift-register chain. It accepts WIDTH-bit words over a valid/ready handshake and buffers one word behind the word being shifted. It emits each word MSB-first on `serial_out`, with a one-cycle `shift_en` strobe per bit, so that the downstream SIPO reassembles the original word. Optional bit-period stretching allows slow serial links.

## Interface
- `WIDTH`, 8, word width in bits; must be ≥ 2.
- `CLKS_PER_BIT`, 1, clock cycles per serial bit; must be ≥ 1.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  upstream word present.
- `in_data`  in  WIDTH  upstream word; must be held stable while `in_valid` is high and `in_ready` is low.
- `in_ready`  out  1  hold buffer empty; a word is accepted when `in_valid && in_ready` at a rising edge.
- `serial_out`  out  1  current serial bit; driven to 0 when not shifting.
- `shift_en`  out  1  one-cycle strobe; the downstream stage samples `serial_out` on this cycle.
- `word_done`  out  1  high together with the strobe of the final (LSB) bit of a word.
- `busy`  out  1  a word is either shifting or held in the buffer.

## Operation
- **State:**
  - FSM with states IDLE and SHIFT.
  - WIDTH-bit shift register `shreg`.
  - Bit counter, width clog2(WIDTH)+1.
  - Divider counter, width clog2(CLKS_PER_BIT)+1.
  - One-entry hold buffer: `hold_data` plus `hold_valid`.
- **Handshake:**
  - `in_ready` = !`hold_valid`, which is a pure register decode.
  - On accept, `hold_data` <= `in_data` and `hold_valid` <= 1.
  - Accept is blocked only while the hold buffer is full. It is never blocked because a word is shifting.
- **IDLE:**
  - If `hold_valid` is set, then `shreg` <= `hold_data`, `hold_valid` <= 0, bit count <= 0, div <= 0, and the FSM moves to SHIFT.
- **SHIFT:**
  - `serial_out` = `shreg[WIDTH-1]`.
  - The divider counts 0..CLKS_PER_BIT-1.
  - `shift_en` = (div == CLKS_PER_BIT-1).
  - On the `shift_en` cycle: `shreg` shifts left with 0 filled at the LSB, bit count increments, and div <= 0.
- **End of word:**
  - `word_done` = `shift_en` && bit count == WIDTH-1.
  - On that cycle, if `hold_valid` is set, the next word loads directly and the FSM stays in SHIFT. There is no gap cycle.
  - Otherwise the FSM returns to IDLE.
- **Simultaneous events:**
  - The hold buffer cannot be written and drained in the same cycle, because `in_ready` is 0 whenever `hold_valid` is 1.
  - A word accepted in the same cycle as `word_done` reaches the hold buffer too late for an immediate reload. The FSM goes to IDLE, then loads on the following cycle, which gives a one-cycle gap.
- `busy` = (state == SHIFT) || `hold_valid`.

## Timing
- **Reset values (asynchronous, while `rst_n` = 0):**
  - Outputs: `serial_out` 0, `shift_en` 0, `word_done` 0, `busy` 0, `in_ready` 1.
  - Internal state: FSM IDLE, `shreg` 0, all counters 0, hold buffer empty.
- **Latency:**
  - Accept at edge N. The word loads at edge N+1. The MSB is visible on `serial_out` from N+1.
  - The first `shift_en` falls in the cycle ending at edge N+CLKS_PER_BIT+1.
- **Word duration:** WIDTH×CLKS_PER_BIT cycles. For back-to-back words loaded from the buffer, the strobes are exactly CLKS_PER_BIT apart across the word boundary.
- **Output timing:** all outputs decode from registers. There is no combinational path from `in_valid` or `in_data` to any output.
- **Reset mid-word:** the partial word and the buffered word are discarded. After `rst_n` deasserts, no `shift_en` occurs until a new accept. The downstream SIPO must be reset in the same event so that the two bit counters stay aligned.

## Structure
- **Shared package `shift_reg_pkg`:**
  - FSM state encoding: IDLE = 0, SHIFT = 1.
  - Counter-width helper, clog2(N)+1.
  - Also used by the SIPO and future stages.
- **Sub-module `bit_tick_gen`:**
  - Divider counter with inputs `clk`, `rst_n`, `clr`, `en`, and output `tick`.
  - Generates `shift_en`.
  - Reusable by the parallel-out side for timeout and pacing.
- **Top level:** the handshake/hold buffer, the FSM, `shreg`, and the bit counter remain in `piso_serializer`.

## Test plan
- **Single word:** WIDTH=8, CLKS_PER_BIT=1, accept 0xA5 when idle. Required:
  - `serial_out` = 1,0,1,0,0,1,0,1 on 8 consecutive `shift_en` cycles.
  - `word_done` on the 8th strobe.
  - A looped-back SIPO shows `parallel_out` = 0xA5 with `data_valid` = 1.
- **Back-to-back:** accept 0xA5 then 0x3C with `in_valid` held high. Required:
  - 16 consecutive `shift_en` cycles with no gap.
  - `in_ready` = 0 while 0x3C sits in the buffer.
  - The SIPO produces 0xA5 and then 0x3C, with `data_valid` 8 cycles apart.
- **Bit stretching:** CLKS_PER_BIT=4, word 0x81. Required:
  - Each bit holds for 4 cycles.
  - `shift_en` fires once per 4 cycles, 8 strobes in total.
  - `busy` is high for 33 cycles, counting from the accept edge.
- **Backpressure:** fill the shifter and the buffer, then present 0x55 with `in_valid` = 1. Required:
  - `in_ready` stays 0 until the buffer drains.
  - 0x55 is accepted exactly once and transmitted third, with no duplication or loss.
- **Reset mid-word:** assert `rst_n` = 0 after 3 strobes of 0xF0. Required:
  - All outputs take their reset values immediately, asynchronously.
  - After release, the next accepted word 0x0F is received intact.
- **Idle:** `in_valid` = 0 for 50 cycles after reset. Required:
  - `shift_en`, `serial_out`, `busy` and `word_done` stay 0.
  - `in_ready` stays 1.
